// File: rtl/conf_cal_pkg.sv
// Shared types and constants for the inverter-pair strength calibration controller.
// Holds the FSM and phase enums plus the idle/reset drive pattern.
package conf_cal_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSet,
    StSettle,
    StSample,
    StDecide,
    StDoneS,
    StFail
  } state_e;

  typedef enum logic {
    PhaseP,
    PhaseN
  } phase_e;

  // Idle drive: up-inverter codes all ones, down-inverter codes (the complement) all zeros.
  localparam logic RstUpBit = 1'b1;

  localparam logic [1:0] FbHigh = 2'b10;
  localparam logic [1:0] FbLow  = 2'b01;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conf_cal_vote.sv
// Majority voter for comparator feedback: counts high/low/invalid samples over one
// decision window and reports whether the bit should be cleared or the trial failed.
module conf_cal_vote
  import conf_cal_pkg::*;
#(
  parameter int unsigned VOTES = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] fb_i,
  output logic       fail_o,
  output logic       high_o
);

  localparam int unsigned CntW = clog2_min1(VOTES + 1);

  logic [CntW-1:0] high_q, low_q, inv_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      high_q <= '0;
      low_q  <= '0;
      inv_q  <= '0;
    end else if (clr_i) begin
      high_q <= '0;
      low_q  <= '0;
      inv_q  <= '0;
    end else if (en_i) begin
      unique case (fb_i)
        FbHigh:  high_q <= high_q + CntW'(1);
        FbLow:   low_q  <= low_q + CntW'(1);
        default: inv_q  <= inv_q + CntW'(1);
      endcase
    end
  end

  assign fail_o = inv_q > CntW'(VOTES / 2);
  assign high_o = high_q > low_q;

endmodule

// File: rtl/conf_cal_ctrl.sv
// Successive-approximation calibration of PMOS then NMOS strength codes for a
// complementary inverter pair, driven by a voted comparator decision per bit.
module conf_cal_ctrl
  import conf_cal_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned VOTES         = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             O_INVU,
  input  logic             O_INVD,
  output logic [WIDTH-1:0] INVU_PCONF,
  output logic [WIDTH-1:0] INVU_NCONF,
  output logic [WIDTH-1:0] INVD_PCONF,
  output logic [WIDTH-1:0] INVD_NCONF,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int unsigned IdxW   = clog2_min1(WIDTH);
  localparam int unsigned CntMax = (SETTLE_CYCLES > VOTES) ? SETTLE_CYCLES : VOTES;
  localparam int unsigned CntW   = clog2_min1(CntMax + 1);

  localparam logic [WIDTH-1:0] RstCode    = {WIDTH{RstUpBit}};
  localparam logic [IdxW-1:0]  IdxTop     = IdxW'(WIDTH - 1);
  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  VoteLast   = CntW'(VOTES - 1);

  state_e           state_q;
  phase_e           phase_q;
  logic [IdxW-1:0]  idx_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] pcode_q, ncode_q;
  logic             busy_q, done_q, err_q;

  logic vote_clr, vote_en, vote_fail, vote_high;

  assign vote_clr = (state_q == StSet);
  assign vote_en  = (state_q == StSample);

  conf_cal_vote #(
    .VOTES (VOTES)
  ) u_vote (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (vote_clr),
    .en_i   (vote_en),
    .fb_i   ({O_INVU, O_INVD}),
    .fail_o (vote_fail),
    .high_o (vote_high)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      phase_q <= PhaseP;
      idx_q   <= '0;
      cnt_q   <= '0;
      pcode_q <= RstCode;
      ncode_q <= RstCode;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ABORT && (state_q != StIdle)) begin
      // Abort wins over any in-flight decision and leaves ERR untouched.
      state_q <= StIdle;
      cnt_q   <= '0;
      pcode_q <= RstCode;
      ncode_q <= RstCode;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            pcode_q <= '0;
            ncode_q <= '1;
            idx_q   <= IdxTop;
            phase_q <= PhaseP;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StSet;
          end
        end
        StSet: begin
          if (phase_q == PhaseP) pcode_q[idx_q] <= 1'b1;
          else                   ncode_q[idx_q] <= 1'b1;
          cnt_q   <= '0;
          state_q <= (SETTLE_CYCLES == 0) ? StSample : StSettle;
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q   <= '0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StSample: begin
          if (cnt_q == VoteLast) begin
            cnt_q   <= '0;
            state_q <= StDecide;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDecide: begin
          if (vote_fail) begin
            pcode_q <= RstCode;
            ncode_q <= RstCode;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFail;
          end else begin
            // Comparator says this trial is too strong: drop the bit.
            if (vote_high) begin
              if (phase_q == PhaseP) pcode_q[idx_q] <= 1'b0;
              else                   ncode_q[idx_q] <= 1'b0;
            end
            if (idx_q != '0) begin
              idx_q   <= idx_q - IdxW'(1);
              state_q <= StSet;
            end else if (phase_q == PhaseP) begin
              phase_q <= PhaseN;
              ncode_q <= '0;
              idx_q   <= IdxTop;
              state_q <= StSet;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDoneS;
            end
          end
        end
        StDoneS: state_q <= StIdle;
        StFail:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign INVU_PCONF = pcode_q;
  assign INVD_PCONF = ~pcode_q;
  assign INVU_NCONF = ncode_q;
  assign INVD_NCONF = ~ncode_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_conf_cal_ctrl.sv
// Directed bench for conf_cal_ctrl: comparator plant model, scoreboarded calibration
// results, fail/abort/async-reset scenarios.
module tb_conf_cal_ctrl;

  localparam int unsigned W = 16;

  logic         CLK = 1'b0;
  logic         RST, START, ABORT, O_INVU, O_INVD;
  logic [W-1:0] INVU_PCONF, INVU_NCONF, INVD_PCONF, INVD_NCONF;
  logic         BUSY, DONE, ERR;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0: threshold plant, 1: hold low, 2: always invalid

  typedef struct {
    logic [W-1:0] pu;
    logic [W-1:0] pd;
    logic [W-1:0] nu;
    logic [W-1:0] nd;
    logic         err;
    int           done_at;
  } exp_t;

  exp_t sb[$];

  conf_cal_ctrl #(
    .WIDTH         (W),
    .SETTLE_CYCLES (8),
    .VOTES         (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .ABORT      (ABORT),
    .O_INVU     (O_INVU),
    .O_INVD     (O_INVD),
    .INVU_PCONF (INVU_PCONF),
    .INVU_NCONF (INVU_NCONF),
    .INVD_PCONF (INVD_PCONF),
    .INVD_NCONF (INVD_NCONF),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  // Plant: NMOS code is all ones only while the PMOS phase is running.
  always_comb begin
    {O_INVU, O_INVD} = 2'b01;
    case (mode)
      0: begin
        if (INVU_NCONF == 16'hFFFF)
          {O_INVU, O_INVD} = (INVU_PCONF >= 16'h5A3C) ? 2'b10 : 2'b01;
        else
          {O_INVU, O_INVD} = (INVU_NCONF >= 16'h1234) ? 2'b10 : 2'b01;
      end
      2: {O_INVU, O_INVD} = 2'b11;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_invu_p"}, INVU_PCONF, 16'hFFFF);
    chk({tag, "_invu_n"}, INVU_NCONF, 16'hFFFF);
    chk({tag, "_invd_p"}, INVD_PCONF, 16'h0000);
    chk({tag, "_invd_n"}, INVD_NCONF, 16'h0000);
    chk({tag, "_busy"}, BUSY, 1'b0);
  endtask

  task automatic calibrate(input string tag, input exp_t e);
    int   got;
    exp_t x;
    got = -1;
    sb.push_back(e);
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int n = 1; n <= 1000; n++) begin
      tick();
      if (n == 1) chk({tag, "_busy_run"}, BUSY, 1'b1);
      if (DONE) begin
        got = n;
        break;
      end
    end
    x = sb.pop_front();
    chk({tag, "_done_edge"}, got, x.done_at);
    chk({tag, "_invu_p"}, INVU_PCONF, x.pu);
    chk({tag, "_invd_p"}, INVD_PCONF, x.pd);
    chk({tag, "_invu_n"}, INVU_NCONF, x.nu);
    chk({tag, "_invd_n"}, INVD_NCONF, x.nd);
    chk({tag, "_err"}, ERR, x.err);
    chk({tag, "_busy_end"}, BUSY, 1'b0);
    tick();
    chk({tag, "_done_pulse"}, DONE, 1'b0);
  endtask

  initial begin
    exp_t e_thr, e_low, e_fail;
    int   done_seen;
    e_thr  = exp_t'{16'h5A3B, 16'hA5C4, 16'h1233, 16'hEDCC, 1'b0, 416};
    e_low  = exp_t'{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 416};
    e_fail = exp_t'{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 13};

    RST   = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    tick();
    tick();
    chk_reset_outputs("in_reset");
    chk("in_reset_done", DONE, 1'b0);
    chk("in_reset_err", ERR, 1'b0);
    RST = 1'b0;
    ABORT = 1'b1;  // ignored in idle
    tick();
    ABORT = 1'b0;
    chk_reset_outputs("post_reset");

    mode = 0;
    calibrate("thresh", e_thr);

    mode = 1;
    calibrate("hold_low", e_low);

    mode = 2;
    calibrate("invalid", e_fail);
    repeat (3) tick();
    chk("err_sticky", ERR, 1'b1);

    // Abort at edge 100 with a stray START at edge 50.
    mode  = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("restart_err_clr", ERR, 1'b0);
    for (int n = 1; n <= 99; n++) begin
      tick();
      START = (n == 49);
    end
    chk("abort_pre_pcode", INVU_PCONF, 16'h5B00);
    chk("abort_pre_busy", BUSY, 1'b1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk_reset_outputs("abort");
    chk("abort_done", DONE, 1'b0);
    chk("abort_err", ERR, 1'b0);
    done_seen = 0;
    repeat (400) begin
      tick();
      if (DONE) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle_busy", BUSY, 1'b0);

    // Asynchronous reset pulse between clock edges.
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (200) tick();
    chk("pre_rst_busy", BUSY, 1'b1);
    #3;
    RST = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    chk("async_rst_done", DONE, 1'b0);
    #2;
    RST = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", BUSY, 1'b0);
    calibrate("after_rst", e_thr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
